// File: rtl/tpu_pkg.sv
// Shared types and constants for the output-stationary systolic TPU core.
package tpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } tpu_state_t;

    localparam int TPU_N  = 16;
    localparam int TPU_DW = 8;
    localparam int TPU_AW = 32;

    // Zero slices needed after the last K-slice so that it reaches PE(N-1,N-1).
    function automatic int flush_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/tpu_array_core_pe.sv
// One processing element: passes a right and b down through registers and
// accumulates the signed product a*b into a wrapping AW-bit accumulator.
module tpu_pe
    import tpu_pkg::*;
#(
    parameter int DW = TPU_DW,
    parameter int AW = TPU_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_a,
    output logic [DW-1:0] o_b,
    output logic [AW-1:0] o_acc
);
    localparam int PW = 2 * DW;

    logic signed [PW-1:0] w_a_ext;
    logic signed [PW-1:0] w_b_ext;
    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] w_prod_ext;

    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [AW-1:0] r_acc;

    assign w_a_ext    = PW'($signed(i_a));
    assign w_b_ext    = PW'($signed(i_b));
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = AW'(w_prod);

    // Operand pass-through registers and the multiply-accumulate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_clr) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign o_a   = r_a;
    assign o_b   = r_b;
    assign o_acc = r_acc;

endmodule

// File: rtl/tpu_array_core.sv
// N x N output-stationary systolic matrix-multiply core with input skewing,
// ready/valid on both sides and row-by-row result draining.
// Optional build macro: TPU_RELU_EN clamps negative result lanes to zero on DO.
//
// state    | meaning
// ST_IDLE  | waiting for the first K-slice of a job, in_ready=1
// ST_LOAD  | streaming K-slices (bubbles feed zeros), in_ready=1
// ST_FLUSH | feeding 2N-1 zero slices so the last slice reaches every PE
// ST_DRAIN | presenting one accumulator row per handshake on DO
module tpu_array_core
    import tpu_pkg::*;
#(
    parameter int N  = TPU_N,
    parameter int DW = TPU_DW,
    parameter int AW = TPU_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [N*DW-1:0]      mat_DI,
    input  logic [N*DW-1:0]      wei_DI,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*AW-1:0]      DO,
    output logic [$clog2(N)-1:0] out_row,
    output logic                 done
);
    localparam int RW = $clog2(N);
    localparam int CW = $clog2(2 * N);

    tpu_state_t    r_state;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_done;
    logic [N*AW-1:0] r_do;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_cnt;

    logic          w_accept;
    logic          w_last_hs;
    logic [RW-1:0] w_sel_row;
    logic [N*AW-1:0] w_row_data;

    logic [DW-1:0] w_skew_a   [N];
    logic [DW-1:0] w_skew_b   [N];
    logic [DW-1:0] w_pe_a_in  [N][N];
    logic [DW-1:0] w_pe_b_in  [N][N];
    logic [DW-1:0] w_pe_a_out [N][N];
    logic [DW-1:0] w_pe_b_out [N][N];
    logic [AW-1:0] w_acc      [N][N];

    assign w_accept  = r_in_ready && in_valid;
    assign w_last_hs = (r_state == ST_DRAIN) && r_out_valid && out_ready
                       && (r_row == RW'(N - 1));

    // Per-lane skew: one input register plus lane-index extra stages, so A lane r
    // and B lane c arrive r and c cycles late. Bubbles and flush feed zeros.
    for (genvar gl = 0; gl < N; gl++) begin : g_skew
        logic [DW-1:0] r_sa [0:gl];
        logic [DW-1:0] r_sb [0:gl];

        // Shift register chain for this lane.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i <= gl; i++) begin
                    r_sa[i] <= '0;
                    r_sb[i] <= '0;
                end
            end else if (w_last_hs) begin
                for (int i = 0; i <= gl; i++) begin
                    r_sa[i] <= '0;
                    r_sb[i] <= '0;
                end
            end else begin
                r_sa[0] <= w_accept ? mat_DI[DW*gl +: DW] : '0;
                r_sb[0] <= w_accept ? wei_DI[DW*gl +: DW] : '0;
                for (int i = 1; i <= gl; i++) begin
                    r_sa[i] <= r_sa[i-1];
                    r_sb[i] <= r_sb[i-1];
                end
            end
        end

        assign w_skew_a[gl] = r_sa[gl];
        assign w_skew_b[gl] = r_sb[gl];
    end

    // PE grid: a enters at column 0 and moves right, b enters at row 0 and moves down.
    for (genvar gr = 0; gr < N; gr++) begin : g_row
        for (genvar gc = 0; gc < N; gc++) begin : g_col
            if (gc == 0) begin : g_a_edge
                assign w_pe_a_in[gr][gc] = w_skew_a[gr];
            end else begin : g_a_chain
                assign w_pe_a_in[gr][gc] = w_pe_a_out[gr][gc-1];
            end
            if (gr == 0) begin : g_b_edge
                assign w_pe_b_in[gr][gc] = w_skew_b[gc];
            end else begin : g_b_chain
                assign w_pe_b_in[gr][gc] = w_pe_b_out[gr-1][gc];
            end

            tpu_pe #(
                .DW(DW),
                .AW(AW)
            ) u_pe (
                .clk  (clk),
                .rst  (rst),
                .i_clr(w_last_hs),
                .i_a  (w_pe_a_in[gr][gc]),
                .i_b  (w_pe_b_in[gr][gc]),
                .o_a  (w_pe_a_out[gr][gc]),
                .o_b  (w_pe_b_out[gr][gc]),
                .o_acc(w_acc[gr][gc])
            );
        end
    end

    // Row to load into DO next: the current row on the first load, else the following one.
    always_comb begin
        w_sel_row = r_row;
        if (r_out_valid && (r_row != RW'(N - 1))) begin
            w_sel_row = r_row + RW'(1);
        end
    end

    // Drain mux over the selected accumulator row, with optional negative clamp.
    always_comb begin
        w_row_data = '0;
        for (int c = 0; c < N; c++) begin
`ifdef TPU_RELU_EN
            w_row_data[AW*c +: AW] = w_acc[w_sel_row][c][AW-1] ? '0 : w_acc[w_sel_row][c];
`else
            w_row_data[AW*c +: AW] = w_acc[w_sel_row][c];
`endif
        end
    end

    // Control FSM with registered handshake, row index and result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_do        <= '0;
            r_row       <= '0;
            r_cnt       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (in_valid) begin
                        if (in_last) begin
                            r_state    <= ST_FLUSH;
                            r_in_ready <= 1'b0;
                            r_cnt      <= CW'(flush_len(N) - 1);
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_DRAIN;
                        r_row   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_do        <= w_row_data;
                    end else if (out_ready) begin
                        if (r_row == RW'(N - 1)) begin
                            r_state     <= ST_IDLE;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_do        <= '0;
                            r_row       <= '0;
                        end else begin
                            r_row <= r_row + RW'(1);
                            r_do  <= w_row_data;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign done      = r_done;
    assign DO        = r_do;
    assign out_row   = r_row;

endmodule

// File: tb/tb_tpu_array_core.sv
// Directed bench for tpu_array_core (N=4, DW=8, AW=32) with a matrix-product model.
module tb_tpu_array_core;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_last = 1'b0;
    logic [N*DW-1:0] mat_DI = '0;
    logic [N*DW-1:0] wei_DI = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [N*AW-1:0] DO;
    logic [1:0]      out_row;
    logic            done;

    int n_cmp = 0;
    int n_bad = 0;

    int            ga [N][N];
    int            gb [N][N];
    logic [AW-1:0] exp_c [N][N];
    logic [AW-1:0] cap   [N][N];

    int exp_row   = 0;
    bit hs_last   = 1'b0;
    int done_seen = 0;
    int hs_cnt    = 0;

    always #5 clk = ~clk;

    tpu_array_core #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .mat_DI   (mat_DI),
        .wei_DI   (wei_DI),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .DO       (DO),
        .out_row  (out_row),
        .done     (done)
    );

    function automatic logic [AW-1:0] shown(input logic [AW-1:0] v);
`ifdef TPU_RELU_EN
        return v[AW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Every cycle: done must follow the last-row handshake, and any valid row
    // must be the next expected row with the model's values.
    always @(negedge clk) begin
        if (!rst) begin
            exp_row = 0;
            hs_last = 1'b0;
        end else begin
            chk("done_pulse", done, hs_last);
            if (done) done_seen++;
            hs_last = 1'b0;
            if (out_valid) begin
                chk("out_row", out_row, exp_row);
                for (int c = 0; c < N; c++)
                    chk("DO_lane", DO[AW*c +: AW], shown(exp_c[exp_row][c]));
                if (out_ready) begin
                    for (int c = 0; c < N; c++) cap[exp_row][c] = DO[AW*c +: AW];
                    hs_last = (exp_row == N - 1);
                    exp_row = (exp_row + 1) % N;
                    hs_cnt++;
                end
            end
        end
    end

    task automatic set_identity();
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
                ga[r][k] = (r == k) ? 1 : 0;
                gb[r][k] = 4 * r + k + 1;
            end
    endtask

    task automatic run_job(input int K, input bit bubbles, input int stall_row, input bit abort);
        int  k;
        int  j;
        int  sum;
        int  guard;
        bit  gap;
        bit  stalled;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                sum = 0;
                for (int kk = 0; kk < K; kk++) sum += ga[r][kk] * gb[kk][c];
                exp_c[r][c] = AW'(sum);
            end
        k = 0;
        gap = 1'b0;
        while (k < K) begin
            if (bubbles && gap) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                mat_DI   = {N{8'h5A}};
                wei_DI   = {N{8'hA5}};
            end else begin
                in_valid = 1'b1;
                in_last  = (k == K - 1);
                for (int l = 0; l < N; l++) begin
                    mat_DI[DW*l +: DW] = DW'(ga[l][k]);
                    wei_DI[DW*l +: DW] = DW'(gb[k][l]);
                end
            end
            @(negedge clk);
            chk("in_ready_load", in_ready, 1);
            @(posedge clk);
            #1;
            if (in_valid) k++;
            gap = !gap;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        mat_DI   = '0;
        wei_DI   = '0;

        if (abort) begin
            repeat (3) @(posedge clk);
            #2 rst = 1'b0;
            #1;
            chk("abort_in_ready", in_ready, 1);
            chk("abort_out_valid", out_valid, 0);
            chk("abort_done", done, 0);
            chk("abort_out_row", out_row, 0);
            chk("abort_DO_zero", (DO == '0), 1);
            @(posedge clk);
            #1 rst = 1'b1;
            repeat (2 * N + 4) @(posedge clk);
            #1;
            chk("abort_no_out_valid", out_valid, 0);
            chk("abort_idle_ready", in_ready, 1);
            return;
        end

        j = 0;
        @(negedge clk);
        chk("in_ready_drop", in_ready, 0);
        while (!out_valid && j < 40) begin
            @(negedge clk);
            j++;
        end
        chk("latency", j, 2 * N);

        guard = 0;
        stalled = 1'b0;
        while (!done && guard < 60) begin
            @(posedge clk);
            #1;
            guard++;
            if (stall_row >= 0 && !stalled && out_valid && out_row == stall_row) begin
                stalled = 1'b1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    chk("stall_valid", out_valid, 1);
                    chk("stall_row", out_row, stall_row);
                end
                out_ready = 1'b1;
            end
        end
        chk("done_reached", done, 1);
        chk("in_ready_at_done", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_done", done, 0);
        chk("reset_out_row", out_row, 0);
        chk("reset_DO_zero", (DO == '0), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", in_ready, 1);

        set_identity();
        run_job(4, 1'b0, -1, 1'b0);
        chk("model_id_r1c2", exp_c[1][2], 7);
        chk("id_r0c0", cap[0][0], 1);
        chk("id_r0c3", cap[0][3], 4);
        chk("id_r2c1", cap[2][1], 10);
        chk("id_r3c3", cap[3][3], 16);

        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
                ga[r][k] = -1;
                gb[r][k] = 2;
            end
        run_job(4, 1'b0, -1, 1'b0);
`ifdef TPU_RELU_EN
        chk("signed_r2c3", cap[2][3], 32'h0000_0000);
`else
        chk("signed_r2c3", cap[2][3], 32'hFFFF_FFF8);
`endif

        set_identity();
        run_job(4, 1'b1, -1, 1'b0);
        chk("bubble_r3c0", cap[3][0], 13);

        set_identity();
        run_job(4, 1'b0, 1, 1'b0);
        chk("bp_r1c1", cap[1][1], 6);
        chk("bp_r2c3", cap[2][3], 12);

        for (int l = 0; l < N; l++) begin
            ga[l][0] = (l == 0) ? -128 : (l == 1) ? 127 : (l == 2) ? -1 : 5;
            gb[0][l] = (l == 0) ? -128 : (l == 1) ? 127 : (l == 2) ? 3 : -7;
        end
        run_job(1, 1'b0, -1, 1'b0);
        chk("k1_r0c0", cap[0][0], 32'h0000_4000);
        chk("k1_r3c2", cap[3][2], 15);

        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
                ga[r][k] = r * 7 - k * 11 - 3;
                gb[k][r] = 13 - r * 9 + k * 5;
            end
        run_job(3, 1'b0, -1, 1'b0);

        set_identity();
        run_job(4, 1'b0, -1, 1'b1);

        set_identity();
        run_job(4, 1'b0, -1, 1'b0);
        chk("rerun_r2c2", cap[2][2], 11);
        chk("rerun_r1c0", cap[1][0], 5);

        repeat (3) @(posedge clk);
        #1;
        chk("done_count", done_seen, 7);
        chk("row_hs_count", hs_cnt, 7 * N);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
